// File: rtl/fp_add_align_stage_pkg.sv
// fp_add_align_stage_pkg: shared float formats and op encoding for the add/sub/compare front end
package fp_add_align_stage_pkg;
  localparam int FP32_EXP_WIDTH = 8;
  localparam int FP32_SIG_WIDTH = 23;
  localparam int FP16_EXP_WIDTH = 5;
  localparam int FP16_SIG_WIDTH = 10;
  typedef enum logic [1:0] {
    FP_ADD = 2'd0,
    FP_SUB = 2'd1,
    FP_CMP = 2'd2
  } fp_add_op_t;
endpackage

// File: rtl/fp_align_lane.sv
// fp_align_lane: classify, order and compute alignment for one operand pair
module fp_align_lane
  import fp_add_align_stage_pkg::*;
#(
  parameter int EXP_WIDTH = FP32_EXP_WIDTH,
  parameter int SIG_WIDTH = FP32_SIG_WIDTH,
  localparam int FW = 1 + EXP_WIDTH + SIG_WIDTH,
  localparam int SHIFT_MAX = SIG_WIDTH + 4,
  localparam int SW = $clog2(SHIFT_MAX + 1),
  localparam int LW = 2 * (SIG_WIDTH + 1) + SW + EXP_WIDTH + 4
) (
  input  logic [1:0]    op,
  input  logic          ftz_en,
  input  logic [FW-1:0] operand1,
  input  logic [FW-1:0] operand2,
  output logic [LW-1:0] result
);
  logic s1, s2, z1, z2, inf1, inf2, nan1, nan2, is_sub, op1_larger;
  logic logical_subtract, result_sign, is_nan, is_inf;
  logic [EXP_WIDTH-1:0] e1, e2, exponent;
  logic [SIG_WIDTH:0] m1, m2, sig_le, sig_se;
  logic [EXP_WIDTH:0] diff;
  logic [SW-1:0] align_shift;
  // classify both operands, pick the larger-exponent lane and clamp the shift
  always_comb begin
    s1 = operand1[FW-1];
    s2 = operand2[FW-1];
    e1 = operand1[FW-2:SIG_WIDTH];
    e2 = operand2[FW-2:SIG_WIDTH];
    z1 = e1 == '0;
    z2 = e2 == '0;
    inf1 = &e1 && operand1[SIG_WIDTH-1:0] == '0;
    inf2 = &e2 && operand2[SIG_WIDTH-1:0] == '0;
    nan1 = &e1 && operand1[SIG_WIDTH-1:0] != '0;
    nan2 = &e2 && operand2[SIG_WIDTH-1:0] != '0;
    m1 = {!z1, operand1[SIG_WIDTH-1:0] & {SIG_WIDTH{!(ftz_en && z1)}}};
    m2 = {!z2, operand2[SIG_WIDTH-1:0] & {SIG_WIDTH{!(ftz_en && z2)}}};
    is_sub = op != FP_ADD;
    op1_larger = e1 > e2 || (e1 == e2 && m1 >= m2);
    diff = op1_larger ? {1'b0, e1} - {1'b0, e2} : {1'b0, e2} - {1'b0, e1};
    align_shift = diff > SHIFT_MAX[EXP_WIDTH:0] ? SHIFT_MAX[SW-1:0] : diff[SW-1:0];
    sig_le = op1_larger ? m1 : m2;
    sig_se = op1_larger ? m2 : m1;
    exponent = op1_larger ? e1 : e2;
    logical_subtract = s1 ^ s2 ^ is_sub;
    result_sign = op1_larger ? s1 : s2 ^ is_sub;
    is_nan = nan1 || nan2 || (inf1 && inf2 && logical_subtract);
    is_inf = !is_nan && (inf1 || inf2);
  end
  assign result = {sig_le, sig_se, align_shift, exponent, logical_subtract, result_sign, is_nan, is_inf};
endmodule

// File: rtl/fp_add_align_stage.sv
// fp_add_align_stage: per-lane operand alignment behind a two-entry skid buffer with rollback squash
module fp_add_align_stage
  import fp_add_align_stage_pkg::*;
#(
  parameter int LANES = 16,
  parameter int EXP_WIDTH = FP32_EXP_WIDTH,
  parameter int SIG_WIDTH = FP32_SIG_WIDTH,
  parameter int THREAD_IDX_WIDTH = 2,
  localparam int FW = 1 + EXP_WIDTH + SIG_WIDTH,
  localparam int SHIFT_MAX = SIG_WIDTH + 4,
  localparam int SW = $clog2(SHIFT_MAX + 1)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [1:0]                       in_op,
  input  logic [THREAD_IDX_WIDTH-1:0]      in_thread_idx,
  input  logic [LANES-1:0]                 in_mask,
  input  logic [LANES*FW-1:0]              in_operand1,
  input  logic [LANES*FW-1:0]              in_operand2,
  input  logic                             ftz_en,
  input  logic                             rollback_en,
  input  logic [THREAD_IDX_WIDTH-1:0]      rollback_thread_idx,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [THREAD_IDX_WIDTH-1:0]      out_thread_idx,
  output logic [LANES-1:0]                 out_mask,
  output logic [1:0]                       out_op,
  output logic [LANES*(SIG_WIDTH+1)-1:0]   out_significand_le,
  output logic [LANES*(SIG_WIDTH+1)-1:0]   out_significand_se,
  output logic [LANES*SW-1:0]              out_align_shift,
  output logic [LANES*EXP_WIDTH-1:0]       out_exponent,
  output logic [LANES-1:0]                 out_logical_subtract,
  output logic [LANES-1:0]                 out_result_sign,
  output logic [LANES-1:0]                 out_is_nan,
  output logic [LANES-1:0]                 out_is_inf
);
  typedef struct packed {
    logic [SIG_WIDTH:0]   le;
    logic [SIG_WIDTH:0]   se;
    logic [SW-1:0]        shift;
    logic [EXP_WIDTH-1:0] exponent;
    logic                 logical_subtract;
    logic                 result_sign;
    logic                 is_nan;
    logic                 is_inf;
  } fp_align_lane_t;
  typedef struct packed {
    logic [THREAD_IDX_WIDTH-1:0] thread_idx;
    logic [LANES-1:0]            mask;
    logic [1:0]                  op;
    fp_align_lane_t [LANES-1:0]  lane;
  } beat_t;
  fp_align_lane_t [LANES-1:0] lane_res;
  beat_t in_beat, out_q, skid_q;
  logic out_v, skid_v, acc, out_keep, skid_keep;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    fp_align_lane #(.EXP_WIDTH(EXP_WIDTH), .SIG_WIDTH(SIG_WIDTH)) u_lane (
      .op(in_op),
      .ftz_en(ftz_en),
      .operand1(in_operand1[i*FW +: FW]),
      .operand2(in_operand2[i*FW +: FW]),
      .result(lane_res[i])
    );
    assign out_significand_le[i*(SIG_WIDTH+1) +: SIG_WIDTH+1] = out_q.lane[i].le;
    assign out_significand_se[i*(SIG_WIDTH+1) +: SIG_WIDTH+1] = out_q.lane[i].se;
    assign out_align_shift[i*SW +: SW] = out_q.lane[i].shift;
    assign out_exponent[i*EXP_WIDTH +: EXP_WIDTH] = out_q.lane[i].exponent;
    assign out_logical_subtract[i] = out_q.lane[i].logical_subtract;
    assign out_result_sign[i] = out_q.lane[i].result_sign;
    assign out_is_nan[i] = out_q.lane[i].is_nan;
    assign out_is_inf[i] = out_q.lane[i].is_inf;
  end
  assign in_beat = {in_thread_idx, in_mask, in_op, lane_res};
  assign in_ready = !skid_v;
  assign out_valid = out_v;
  assign out_thread_idx = out_q.thread_idx;
  assign out_mask = out_q.mask;
  assign out_op = out_q.op;
  // which entries survive this cycle: OUT stays only if not drained or squashed
  always_comb begin
    acc = in_valid && in_ready && !(rollback_en && in_thread_idx == rollback_thread_idx);
    out_keep = out_v && !out_ready && !(rollback_en && out_q.thread_idx == rollback_thread_idx);
    skid_keep = skid_v && !(rollback_en && skid_q.thread_idx == rollback_thread_idx);
  end
  // oldest surviving beat always lands in OUT, the next one in SKID
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_v <= 1'b0;
      skid_v <= 1'b0;
      out_q <= '0;
      skid_q <= '0;
    end else begin
      out_v <= out_keep || skid_keep || acc;
      skid_v <= out_keep && (skid_keep || acc);
      if (!out_keep && (skid_keep || acc)) out_q <= skid_keep ? skid_q : in_beat;
      if (out_keep && acc) skid_q <= in_beat;
    end
  end
endmodule

// File: tb/tb_fp_add_align_stage.sv
// tb_fp_add_align_stage: scoreboard bench for the align stage handshake and datapath
module tb_fp_add_align_stage;
  import fp_add_align_stage_pkg::*;
  localparam int L = 16;
  localparam int HL = 4;
  logic clk = 0;
  logic reset = 0;
  logic in_valid, in_ready, ftz_en, rollback_en, out_valid, out_ready;
  logic [1:0] in_op, in_thread_idx, rollback_thread_idx, out_thread_idx, out_op;
  logic [L-1:0] in_mask, out_mask, out_logical_subtract, out_result_sign, out_is_nan, out_is_inf;
  logic [L*32-1:0] in_operand1, in_operand2;
  logic [L*24-1:0] out_significand_le, out_significand_se;
  logic [L*5-1:0] out_align_shift;
  logic [L*8-1:0] out_exponent;
  logic h_in_valid, h_in_ready, h_out_valid;
  logic [1:0] h_out_thread_idx, h_out_op;
  logic [HL-1:0] h_out_mask, h_ls, h_sg, h_nan, h_inf;
  logic [HL*16-1:0] h_op1, h_op2;
  logic [HL*11-1:0] h_le, h_se;
  logic [HL*4-1:0] h_sh;
  logic [HL*5-1:0] h_ex;
  typedef struct {
    logic [1:0] op;
    logic [31:0] a, b;
    logic ftz;
    logic [23:0] le, se;
    logic [4:0] sh;
    logic [7:0] ex;
    logic ls, sg, nan, inf;
  } vec_t;
  typedef struct {
    int vi;
    logic [1:0] thr;
    logic [15:0] mask;
  } exp_t;
  vec_t vt [10];
  exp_t q [$];
  exp_t me;
  vec_t mv;
  logic [64:0] got, want;
  logic bad;
  int tests = 0, fails = 0, pops = 0, n0;
  always #5 clk = ~clk;
  fp_add_align_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_thread_idx(in_thread_idx), .in_mask(in_mask), .in_operand1(in_operand1),
    .in_operand2(in_operand2), .ftz_en(ftz_en), .rollback_en(rollback_en),
    .rollback_thread_idx(rollback_thread_idx), .out_valid(out_valid), .out_ready(out_ready),
    .out_thread_idx(out_thread_idx), .out_mask(out_mask), .out_op(out_op),
    .out_significand_le(out_significand_le), .out_significand_se(out_significand_se),
    .out_align_shift(out_align_shift), .out_exponent(out_exponent),
    .out_logical_subtract(out_logical_subtract), .out_result_sign(out_result_sign),
    .out_is_nan(out_is_nan), .out_is_inf(out_is_inf)
  );
  fp_add_align_stage #(.LANES(HL), .EXP_WIDTH(FP16_EXP_WIDTH), .SIG_WIDTH(FP16_SIG_WIDTH)) dut16 (
    .clk(clk), .reset(reset), .in_valid(h_in_valid), .in_ready(h_in_ready), .in_op(2'd0),
    .in_thread_idx(2'd0), .in_mask(4'hF), .in_operand1(h_op1), .in_operand2(h_op2),
    .ftz_en(1'b0), .rollback_en(1'b0), .rollback_thread_idx(2'd0), .out_valid(h_out_valid),
    .out_ready(1'b1), .out_thread_idx(h_out_thread_idx), .out_mask(h_out_mask), .out_op(h_out_op),
    .out_significand_le(h_le), .out_significand_se(h_se), .out_align_shift(h_sh),
    .out_exponent(h_ex), .out_logical_subtract(h_ls), .out_result_sign(h_sg),
    .out_is_nan(h_nan), .out_is_inf(h_inf)
  );
  task automatic check(input string name, input logic [63:0] g, input logic [63:0] w);
    tests++;
    if (g !== w) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, g, w);
    end
  endtask
  task automatic send(input int vi, input logic [1:0] thr, input logic [15:0] mask);
    int n = 0;
    in_valid = 1;
    in_op = vt[vi].op;
    in_thread_idx = thr;
    in_mask = mask;
    ftz_en = vt[vi].ftz;
    for (int i = 0; i < L; i++) begin
      in_operand1[i*32 +: 32] = vt[vi].a;
      in_operand2[i*32 +: 32] = vt[vi].b;
    end
    forever begin
      @(negedge clk);
      if (in_ready && !(rollback_en && rollback_thread_idx == thr)) begin
        q.push_back('{vi, thr, mask});
        @(posedge clk);
        #1;
        break;
      end
      @(posedge clk);
      #1;
      if (++n == 50) begin
        check("send_timeout", 64'd0, 64'd1);
        break;
      end
    end
  endtask
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      pops++;
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_beat: got thread %0d, required no beat", out_thread_idx);
      end else begin
        me = q.pop_front();
        mv = vt[me.vi];
        bad = {out_thread_idx, out_mask, out_op} !== {me.thr, me.mask, mv.op};
        if (bad) $display("FAIL beat_hdr v%0d: got %h, required %h", me.vi,
                          {out_thread_idx, out_mask, out_op}, {me.thr, me.mask, mv.op});
        for (int i = 0; i < L; i++) begin
          got = {out_significand_le[i*24 +: 24], out_significand_se[i*24 +: 24], out_align_shift[i*5 +: 5],
                 out_exponent[i*8 +: 8], out_logical_subtract[i], out_result_sign[i], out_is_nan[i], out_is_inf[i]};
          want = {mv.le, mv.se, mv.sh, mv.ex, mv.ls, mv.sg, mv.nan, mv.inf};
          if (got !== want) begin
            bad = 1;
            $display("FAIL beat_lane v%0d lane%0d: got le/se/sh/ex/flags %h, required %h", me.vi, i, got, want);
          end
        end
        if (bad) fails++;
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1, "timeout");
  end
  initial begin
    vt[0] = '{2'd0, 32'h3F800000, 32'h40000000, 1'b0, 24'h800000, 24'h800000, 5'd1, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[1] = '{2'd1, 32'h40400000, 32'hC0400000, 1'b0, 24'hC00000, 24'hC00000, 5'd0, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[2] = '{2'd1, 32'h3F800000, 32'h40000000, 1'b0, 24'h800000, 24'h800000, 5'd1, 8'h80, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[3] = '{2'd0, 32'h54000000, 32'h40000000, 1'b0, 24'h800000, 24'h800000, 5'd27, 8'hA8, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[4] = '{2'd1, 32'h7F800000, 32'h7F800000, 1'b0, 24'h800000, 24'h800000, 5'd0, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[5] = '{2'd0, 32'h7FC00000, 32'h3F800000, 1'b0, 24'hC00000, 24'h800000, 5'd27, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[6] = '{2'd0, 32'h00000001, 32'h3F800000, 1'b1, 24'h800000, 24'h000000, 5'd27, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[7] = '{2'd0, 32'h00000001, 32'h3F800000, 1'b0, 24'h800000, 24'h000001, 5'd27, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[8] = '{2'd0, 32'h7F800000, 32'h3F800000, 1'b0, 24'h800000, 24'h800000, 5'd27, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[9] = '{2'd2, 32'hBF800000, 32'h3F800000, 1'b0, 24'h800000, 24'h800000, 5'd0, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0};
    in_valid = 0;
    in_op = 0;
    in_thread_idx = 0;
    in_mask = 0;
    in_operand1 = '0;
    in_operand2 = '0;
    ftz_en = 0;
    rollback_en = 0;
    rollback_thread_idx = 0;
    out_ready = 1;
    h_in_valid = 0;
    h_op1 = '0;
    h_op2 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_datapath", 64'(|{out_significand_le, out_exponent, out_align_shift, out_thread_idx}), 64'd0);
    @(posedge clk);
    #1 reset = 1;
    for (int v = 0; v < 10; v++) send(v, 2'(v), 16'hA5A5 ^ 16'(v));
    in_valid = 0;
    repeat (3) @(posedge clk);
    #1 out_ready = 0;
    send(0, 2'd0, 16'h0001);
    send(1, 2'd1, 16'h0002);
    @(negedge clk);
    check("full_in_ready", 64'(in_ready), 64'd0);
    check("full_out_valid", 64'(out_valid), 64'd1);
    @(posedge clk);
    #1 out_ready = 1;
    n0 = pops;
    send(2, 2'd2, 16'h0004);
    in_valid = 0;
    @(negedge clk);
    #1 check("drain_consecutive", 64'(pops - n0), 64'd3);
    @(posedge clk);
    #1 out_ready = 0;
    send(3, 2'd1, 16'h0010);
    send(4, 2'd2, 16'h0020);
    in_valid = 0;
    rollback_en = 1;
    rollback_thread_idx = 1;
    check("squash_target_thread", 64'(q[0].thr), 64'd1);
    q.delete(0);
    @(posedge clk);
    #1 rollback_en = 0;
    @(negedge clk);
    check("squash_out_valid", 64'(out_valid), 64'd1);
    check("squash_promotes_skid", 64'(out_thread_idx), 64'd2);
    check("squash_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 out_ready = 1;
    repeat (2) @(posedge clk);
    #1 n0 = pops;
    in_valid = 1;
    in_thread_idx = 3;
    rollback_en = 1;
    rollback_thread_idx = 3;
    @(posedge clk);
    #1 in_valid = 0;
    rollback_en = 0;
    repeat (3) @(negedge clk);
    #1 check("squash_incoming", 64'(pops - n0), 64'd0);
    @(posedge clk);
    #1 rollback_en = 1;
    rollback_thread_idx = 0;
    send(5, 2'd1, 16'h0040);
    in_valid = 0;
    rollback_en = 0;
    repeat (2) @(posedge clk);
    #1 out_ready = 0;
    send(6, 2'd0, 16'h0100);
    send(7, 2'd3, 16'h0200);
    in_valid = 0;
    #2 reset = 0;
    #1 check("async_reset_out_valid", 64'(out_valid), 64'd0);
    check("async_reset_in_ready", 64'(in_ready), 64'd1);
    q.delete();
    @(posedge clk);
    #1 reset = 1;
    out_ready = 1;
    send(8, 2'd2, 16'hFFFF);
    in_valid = 0;
    for (int i = 0; i < HL; i++) begin
      h_op1[i*16 +: 16] = 16'h3C00;
      h_op2[i*16 +: 16] = 16'h4000;
    end
    h_in_valid = 1;
    @(posedge clk);
    #1 h_in_valid = 0;
    @(negedge clk);
    check("fp16_out_valid", 64'(h_out_valid), 64'd1);
    check("fp16_shift", 64'(h_sh), 64'h1111);
    check("fp16_exponent", 64'(h_ex[4:0]), 64'h10);
    check("fp16_sig_le_se", 64'({h_le[10:0], h_se[10:0]}), 64'({11'h400, 11'h400}));
    check("fp16_flags", 64'({h_ls, h_sg, h_nan, h_inf}), 64'd0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    #1 check("scoreboard_empty", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
